// File: rtl/count_sched.sv
// Round-robin scheduler sharing one serially loaded count-down unit among N_REQ requesters.
// Grants one requester, shifts its count into the unit MSB first, and reports completion.
module count_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic                   cu_start_req_o,
  output logic                   cu_start_data_o,
  output logic                   cu_ready_o,
  input  logic                   cu_result_rsp_i,
  input  logic                   cu_busy_i
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HOLD_W = $clog2(HOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_COUNT,
    S_ACK
  } state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   ptr;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic [WIDTH-1:0]   value;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic               seen_busy;

  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W:0]     cand;
  logic               hold_last;
  logic               bit_last;
  logic [BIT_W-1:0]   msb_idx;

  assign hold_last = (hold_cnt == HOLD_W'(HOLD - 1));
  assign bit_last  = (bit_idx == BIT_W'(WIDTH - 1));
  assign msb_idx   = BIT_W'(WIDTH - 1) - bit_idx;

  // Rotating search: the requester just after the last winner has top priority.
  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (cand >= (PTR_W + 1)'(N_REQ)) cand = cand - (PTR_W + 1)'(N_REQ);
      if (!found && req_i[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (found) state_next = S_LOAD;
      S_LOAD:    if (hold_last && bit_last) state_next = S_RELEASE;
      S_RELEASE: if (hold_last) state_next = S_COUNT;
      // A response is trusted only after the unit has shown busy for this job.
      S_COUNT:   if (seen_busy && cu_result_rsp_i) state_next = S_ACK;
      S_ACK:     if (!cu_busy_i) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= PTR_W'(N_REQ - 1);
      grant     <= '0;
      done      <= '0;
      value     <= '0;
      hold_cnt  <= '0;
      bit_idx   <= '0;
      seen_busy <= 1'b0;
    end else begin
      done <= '0;
      if ((state == S_LOAD || state == S_RELEASE || state == S_COUNT) && cu_busy_i)
        seen_busy <= 1'b1;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant    <= N_REQ'(1) << winner;
            ptr      <= winner;
            value    <= req_data_i[winner*WIDTH +: WIDTH];
            hold_cnt <= '0;
            bit_idx  <= '0;
          end
        end
        S_LOAD: begin
          if (hold_last) begin
            hold_cnt <= '0;
            bit_idx  <= bit_last ? '0 : bit_idx + BIT_W'(1);
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_RELEASE: begin
          if (hold_last) hold_cnt <= '0;
          else           hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        S_ACK: begin
          if (!cu_busy_i) begin
            done      <= grant;
            grant     <= '0;
            seen_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_o         = grant;
  assign done_o          = done;
  assign busy_o          = (state != S_IDLE);
  assign cu_start_req_o  = (state == S_LOAD);
  assign cu_start_data_o = (state == S_LOAD) && value[msb_idx];
  assign cu_ready_o      = (state == S_ACK);

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched with a behavioural serial-load count-down unit.
// Each step compares DUT outputs against hand-computed values via immediate assertions.
module tb_count_sched;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int HOLD  = 2;
  localparam int LIMIT = 3000;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       grant_o;
  logic [N_REQ-1:0]       done_o;
  logic                   busy_o;
  logic                   cu_start_req_o;
  logic                   cu_start_data_o;
  logic                   cu_ready_o;
  logic                   cu_result_rsp_i;
  logic                   cu_busy_i;

  int errors = 0;
  int checks = 0;

  count_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_i           (req_i),
    .req_data_i      (req_data_i),
    .grant_o         (grant_o),
    .done_o          (done_o),
    .busy_o          (busy_o),
    .cu_start_req_o  (cu_start_req_o),
    .cu_start_data_o (cu_start_data_o),
    .cu_ready_o      (cu_ready_o),
    .cu_result_rsp_i (cu_result_rsp_i),
    .cu_busy_i       (cu_busy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit model: shifts in one bit per HOLD cycles, goes busy a few cycles after
  // start_req falls, counts down, raises rsp, and clears busy on ready. rsp stays high afterwards.
  logic [WIDTH-1:0] m_shift;
  logic [WIDTH-1:0] m_cnt;
  logic [4:0]       m_cyc;
  logic [2:0]       m_delay;
  logic             m_sr_q;
  logic             m_busy;
  logic             m_rsp;

  assign cu_busy_i       = m_busy;
  assign cu_result_rsp_i = m_rsp;

  always @(posedge clk) begin
    if (rst) begin
      m_shift <= '0;
      m_cnt   <= '0;
      m_cyc   <= '0;
      m_delay <= '0;
      m_sr_q  <= 1'b0;
      m_busy  <= 1'b0;
      m_rsp   <= 1'b0;
    end else begin
      m_sr_q <= cu_start_req_o;
      if (cu_start_req_o) begin
        m_cyc <= m_cyc + 5'd1;
        if ((int'(m_cyc) % HOLD) == HOLD - 1) m_shift <= {m_shift[WIDTH-2:0], cu_start_data_o};
      end else begin
        m_cyc <= '0;
      end
      if (m_sr_q && !cu_start_req_o) begin
        m_delay <= 3'd4;
      end else if (m_delay != 0) begin
        m_delay <= m_delay - 3'd1;
        if (m_delay == 3'd1) begin
          m_busy <= 1'b1;
          m_rsp  <= 1'b0;
          m_cnt  <= m_shift;
        end
      end
      if (m_busy && !m_rsp) begin
        if (m_cnt == 0) m_rsp <= 1'b1;
        else            m_cnt <= m_cnt - 1'b1;
      end
      if (m_busy && m_rsp && cu_ready_o) m_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_i = '0;
    wait_cycle();
    wait_cycle();
    rst = 1'b0;
  endtask

  // One complete service of requester idx with count value data. With late set, the
  // requester scrambles its data during LOAD and drops its request once the unit is counting.
  task automatic serve(input int idx, input logic [WIDTH-1:0] data, input bit late);
    logic [WIDTH-1:0] d;
    logic [N_REQ-1:0] one;
    int n;
    bit dropped;
    d   = data;
    one = N_REQ'(1) << idx;
    req_data_i[idx*WIDTH +: WIDTH] = data;
    req_i[idx] = 1'b1;
    wait_cycle();
    check("grant_latency", 32'(grant_o), 32'(one));
    if (late) req_data_i[idx*WIDTH +: WIDTH] = ~data;
    else      req_i[idx] = 1'b0;
    for (int k = 0; k < WIDTH * HOLD; k++) begin
      check("load_bit", {30'd0, cu_start_req_o, cu_start_data_o}, {30'd0, 1'b1, d[WIDTH-1-k/HOLD]});
      wait_cycle();
    end
    for (int k = 0; k < HOLD; k++) begin
      check("release_low", {30'd0, cu_start_req_o, cu_start_data_o}, 32'd0);
      wait_cycle();
    end
    n = 0;
    dropped = 1'b0;
    while (!cu_ready_o && n < LIMIT) begin
      if (late && m_busy && !dropped) begin
        req_i[idx] = 1'b0;
        req_data_i[idx*WIDTH +: WIDTH] = 8'hFF;
        dropped = 1'b1;
      end
      wait_cycle();
      n++;
    end
    check("ack_reached", 32'(n < LIMIT), 32'd1);
    check("ack_on_fresh_rsp", {30'd0, m_busy, m_rsp}, 32'd3);
    check("unit_loaded_value", 32'(m_shift), 32'(data));
    check("grant_held", 32'(grant_o), 32'(one));
    n = 0;
    while (done_o == 0 && n < LIMIT) begin
      wait_cycle();
      n++;
    end
    check("done_reached", 32'(n < LIMIT), 32'd1);
    check("done_index", 32'(done_o), 32'(one));
    check("grant_cleared_with_done", 32'(grant_o), 32'd0);
    check("idle_at_done", {30'd0, busy_o, cu_ready_o}, 32'd0);
    wait_cycle();
    check("done_one_cycle", 32'(done_o), 32'd0);
  endtask

  logic [N_REQ-1:0] rot_exp [5];

  initial begin
    int n;
    rst        = 1'b1;
    req_i      = '0;
    req_data_i = '0;
    rot_exp[0] = 4'b0001;
    rot_exp[1] = 4'b0010;
    rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000;
    rot_exp[4] = 4'b0001;

    // Reset state.
    wait_cycle();
    wait_cycle();
    check("reset_grant", 32'(grant_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_ctrl", {28'd0, busy_o, cu_start_req_o, cu_start_data_o, cu_ready_o}, 32'd0);
    rst = 1'b0;
    wait_cycle();

    // Basic service: requester 0, 0xA5.
    serve(0, 8'hA5, 1'b0);

    // Rotation with every requester continuously asserted.
    do_reset();
    req_data_i = {N_REQ{8'h03}};
    req_i      = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      n = 0;
      while (grant_o == 0 && n < LIMIT) begin
        wait_cycle();
        n++;
      end
      check("rot_grant", 32'(grant_o), 32'(rot_exp[s]));
      if (s == 4) req_i = '0;
      n = 0;
      while (done_o == 0 && n < LIMIT) begin
        wait_cycle();
        n++;
      end
      check("rot_done", 32'(done_o), 32'(rot_exp[s]));
      check("rot_grant_clear", 32'(grant_o), 32'd0);
      wait_cycle();
      if (s < 4) check("rot_next_grant_gap", 32'(grant_o), 32'(rot_exp[s+1]));
    end

    // Stale high response from the previous job must not complete a new one.
    check("stale_rsp_high", {30'd0, m_busy, m_rsp}, 32'd1);
    serve(1, 8'h03, 1'b0);

    // Zero count: all-zero serial data, completes normally.
    serve(3, 8'h00, 1'b0);

    // Reset in the middle of LOAD at bit 4.
    req_data_i[2*WIDTH +: WIDTH] = 8'h5A;
    req_i = 4'b0100;
    wait_cycle();
    check("mid_grant", 32'(grant_o), 32'b0100);
    repeat (4 * HOLD) wait_cycle();
    check("mid_bit4", {30'd0, cu_start_req_o, cu_start_data_o}, 32'd3);
    rst   = 1'b1;
    req_i = '0;
    wait_cycle();
    check("abort_outputs", {22'd0, grant_o, done_o, busy_o, cu_start_req_o},
          32'd0);
    check("abort_data_ready", {30'd0, cu_start_data_o, cu_ready_o}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_cycle();
      check("abort_no_done", {24'd0, grant_o, done_o}, 32'd0);
    end
    serve(1, 8'h5A, 1'b0);

    // Requester 2 changes its data during LOAD and drops its request during COUNT.
    serve(2, 8'h05, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
